// File: rtl/uart_top_cfg.sv
// uart_top_cfg: full-duplex UART with configurable data width, parity and stop bits,
// parity/framing error flags and a runtime internal loopback.
module uart_top_cfg #(
    parameter int CLK_HZ    = 50000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 send_data,
    output logic                 tx_busy,
    output logic                 tx,
    input  logic                 rx,
    input  logic                 loopback,
    output logic                 data_valid,
    output logic [DATA_BITS-1:0] parallel_out,
    output logic                 parity_err,
    output logic                 frame_err
);
    localparam int CLKS = CLK_HZ / BAUD;
    localparam int CW = $clog2(STOP_BITS * CLKS + 1);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BIT_END = CW'(CLKS - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS / 2 - 1);
    localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * CLKS - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic ODD = (PARITY == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t tx_state, tx_next;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [BW-1:0] tx_bit, tx_bit_n;
    logic [DATA_BITS-1:0] tx_sh, tx_sh_n;
    logic tx_par, tx_par_n, tx_d;

    assign tx_busy = tx_state != IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_next;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_sh    <= tx_sh_n;
            tx_par   <= tx_par_n;
            tx       <= tx_d;
        end
    end

    always_comb begin
        tx_next  = tx_state;
        tx_cnt_n = tx_cnt + CW'(1);
        tx_bit_n = tx_bit;
        tx_sh_n  = tx_sh;
        tx_par_n = tx_par;
        case (tx_state)
            IDLE: begin
                tx_cnt_n = '0;
                if (send_data) begin
                    tx_next  = START;
                    tx_sh_n  = data;
                    tx_par_n = ^data ^ ODD;
                end
            end
            START: if (tx_cnt == BIT_END) begin
                tx_next  = DATA;
                tx_cnt_n = '0;
            end
            DATA: if (tx_cnt == BIT_END) begin
                tx_cnt_n = '0;
                tx_sh_n  = tx_sh >> 1;
                tx_bit_n = tx_bit + BW'(1);
                if (tx_bit == LAST_BIT) begin
                    tx_bit_n = '0;
                    tx_next  = PARITY != 0 ? PAR : STOP;
                end
            end
            PAR: if (tx_cnt == BIT_END) begin
                tx_next  = STOP;
                tx_cnt_n = '0;
            end
            default: if (tx_cnt == STOP_END) begin
                tx_next  = IDLE;
                tx_cnt_n = '0;
            end
        endcase
        // line level follows the state being entered so tx and tx_state change on the same edge
        tx_d = tx_next == START ? 1'b0 : tx_next == DATA ? tx_sh_n[0] : tx_next == PAR ? tx_par_n : 1'b1;
    end

    state_t rx_state, rx_next;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [BW-1:0] rx_bit, rx_bit_n;
    logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
    logic rx_pbit, rx_pbit_n, done;
    logic s1, s2, s_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1           <= 1'b1;
            s2           <= 1'b1;
            s_prev       <= 1'b1;
            rx_state     <= IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_sh        <= '0;
            rx_pbit      <= 1'b0;
            data_valid   <= 1'b0;
            parallel_out <= '0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            s1         <= loopback ? tx : rx;
            s2         <= s1;
            s_prev     <= s2;
            rx_state   <= rx_next;
            rx_cnt     <= rx_cnt_n;
            rx_bit     <= rx_bit_n;
            rx_sh      <= rx_sh_n;
            rx_pbit    <= rx_pbit_n;
            data_valid <= done;
            if (done) begin
                parallel_out <= rx_sh;
                parity_err   <= (PARITY != 0) && (^rx_sh ^ ODD ^ rx_pbit);
                frame_err    <= !s2;
            end
        end
    end

    always_comb begin
        rx_next   = rx_state;
        rx_cnt_n  = rx_cnt + CW'(1);
        rx_bit_n  = rx_bit;
        rx_sh_n   = rx_sh;
        rx_pbit_n = rx_pbit;
        done      = 1'b0;
        case (rx_state)
            IDLE: begin
                rx_cnt_n = '0;
                if (s_prev && !s2) rx_next = START;
            end
            START: if (rx_cnt == HALF_END) begin
                rx_cnt_n = '0;
                rx_next  = s2 ? IDLE : DATA;
            end
            DATA: if (rx_cnt == BIT_END) begin
                rx_cnt_n = '0;
                rx_sh_n  = {s2, rx_sh[DATA_BITS-1:1]};
                rx_bit_n = rx_bit + BW'(1);
                if (rx_bit == LAST_BIT) begin
                    rx_bit_n = '0;
                    rx_next  = PARITY != 0 ? PAR : STOP;
                end
            end
            PAR: if (rx_cnt == BIT_END) begin
                rx_cnt_n  = '0;
                rx_pbit_n = s2;
                rx_next   = STOP;
            end
            default: if (rx_cnt == BIT_END) begin
                rx_cnt_n = '0;
                rx_next  = IDLE;
                done     = 1'b1;
            end
        endcase
    end
endmodule

// File: doc/uart_top_cfg.md
Name: uart_top_cfg

Overview:
- Parametrised successor to the fixed 8N1 UART loopback top.
- Full-duplex UART transceiver with configurable frame format:
  - data width 5-9 bits
  - optional even/odd parity
  - 1 or 2 stop bits
- Provides parity and framing error flags, plus a runtime internal loopback select.
- Sits between the parallel host logic and the serial pins; its own testbench reuses the send_data/data_valid handshake.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate. CLKS_PER_BIT = CLK_HZ/BAUD (integer division, must be >= 4).
- DATA_BITS, 8, payload width, legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits transmitted, 1 or 2. The receiver checks only the first.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset. One clock; reset is asynchronous and active-low.
- data  input  DATA_BITS  transmit payload, sampled when send_data is accepted.
- send_data  input  1  transmit request, accepted when tx_busy=0.
- tx_busy  output  1  transmitter occupied.
- tx  output  1  serial out, idle high.
- rx  input  1  serial in, asynchronous to clk.
- loopback  input  1  1 = receiver takes the internal tx instead of the rx pin.
- data_valid  output  1  one-cycle pulse when a frame is received.
- parallel_out  output  DATA_BITS  last received payload.
- parity_err  output  1  parity mismatch on the last frame.
- frame_err  output  1  first stop bit sampled low on the last frame.

Behaviour:
- Reset (rst=0, asynchronous, including mid-frame) forces:
  - tx=1, tx_busy=0, data_valid=0, parallel_out=0, parity_err=0, frame_err=0
  - both FSMs to IDLE and all counters to 0
  - Frame in progress is abandoned; nothing is delivered after release.
- Bit order: LSB first. Frame = start(0), DATA_BITS payload, optional parity, stop bit(s) (1).
- Parity bit:
  - even: XOR of payload
  - odd: inverted XOR of payload
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
  - Each state holds the line for CLKS_PER_BIT cycles. STOP lasts STOP_BITS*CLKS_PER_BIT.
  - Accept: send_data=1 while tx_busy=0 registers data.
  - On the next edge: tx_busy=1 and tx=0.
  - tx_busy returns to 0 on the cycle after the final stop-bit period ends.
  - send_data while tx_busy=1 is ignored (no queue). Holding send_data high starts back-to-back frames with no idle gap.
- RX input path:
  - Source = loopback ? internal tx : rx.
  - Source goes through a 2-flop synchroniser before the FSM.
- RX FSM: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE.
  - IDLE: a synchronised falling edge starts a counter.
  - START: at CLKS_PER_BIT/2 the line is resampled. If high, this is a glitch: return to IDLE with no output.
  - DATA, PARITY, STOP: each bit is sampled once, CLKS_PER_BIT cycles after the previous sample (mid-bit).
  - At the first stop-bit sample, in the same cycle: data_valid=1 for exactly one cycle; parallel_out, parity_err and frame_err are updated.
  - parallel_out and the error flags hold until the next data_valid.
  - parity_err is always 0 when PARITY=0.
  - A frame with errors still delivers data_valid.
  - After the stop sample the receiver returns to IDLE immediately, so it tolerates 1 stop bit from the far end.
- Latency in loopback, measured from the accept cycle to the data_valid pulse: 2 synchroniser cycles, plus one cycle for the tx register, plus (1 + DATA_BITS + P + 0.5) bit times. P is 1 with parity enabled, else 0. Bench tolerance: ±2 cycles.
- tx and rx paths are fully independent: simultaneous transmit and receive on pins is supported.
- Toggling loopback mid-frame is undefined. The bench changes it only while both FSMs are IDLE.

Test Plan:
- Setup for all cases: CLK_HZ=1000000, BAUD=100000 (10 clks/bit).
- Reset and idle: rst=0 for 2 cycles, then released -> tx=1, tx_busy=0, data_valid=0, parallel_out=0, both flags 0; no activity for 200 cycles.
- Loopback 8N1, two frames:
  - send 8'h55, then 8'hAA after tx_busy falls -> one data_valid per frame.
  - parallel_out=8'h55 then 8'hAA; errors 0.
  - tx_busy high for 100 cycles per frame.
- Even parity, DATA_BITS=7, loopback:
  - send 7'h07 -> tx parity bit =1; parallel_out=7'h07, parity_err=0.
  - Then drive rx externally, loopback=0, with 7'h07 and parity bit 0 -> data_valid with parity_err=1.
- Framing and glitch on rx pin, loopback=0:
  - frame 8'hC3 with stop bit driven 0 -> data_valid, parallel_out=8'hC3, frame_err=1.
  - 3-cycle low glitch -> no data_valid.
- Busy rejection and 2 stop bits, STOP_BITS=2:
  - send 8'h12, then pulse send_data with 8'h34 mid-frame -> only 8'h12 received.
  - tx_busy high for 110 cycles.
- Async reset mid-frame: assert rst during bit 4 of 8'hF0 -> tx=1 and tx_busy=0 immediately without waiting for a clock edge; no data_valid afterwards.
